// File: rtl/sif_xa_arbiter.sv
// sif_xa_arbiter: round-robin sequencer sharing the single SIF XA access
// port between N_REQ requesters. One transaction at a time; reads hold the
// bus for RD_LAT cycles and return data to the requester that issued them.
module sif_xa_arbiter #(
  parameter int N_REQ  = 4,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_rdata,
  output logic                xa_wr_s,
  output logic                xa_rd_s,
  output logic [AW-1:0]       xa_addr,
  output logic [DW-1:0]       xa_data_wr,
  input  logic [DW-1:0]       xa_data_rd,
  output logic                busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = IW + 1;
  localparam int CW = 4;
  localparam logic [SW-1:0] NREQ_S = SW'(N_REQ);
  localparam logic [CW-1:0] LAT_LOAD = CW'(RD_LAT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            wr_s_q, wr_s_d;
  logic            rd_s_q, rd_s_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            busy_q, busy_d;

  // Arbitration signals: requests rotated so that ptr sits at bit 0
  logic [N_REQ-1:0] req_rot;
  logic [IW-1:0]    win_off;
  logic [SW-1:0]    win_sum;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_wdata;
  logic             win_we;

  // Round-robin pick: lowest set bit of the rotated vector, mapped back to
  // an absolute requester index by adding ptr modulo N_REQ.
  always_comb begin
    req_rot = N_REQ'({req, req} >> ptr_q);
    win_off = '0;
    win_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_off = IW'(k);
        win_any = 1'b1;
      end
    end
    win_sum = {1'b0, ptr_q} + {1'b0, win_off};
    if (win_sum >= NREQ_S) begin
      win_sum = win_sum - NREQ_S;
    end
    win_idx   = win_sum[IW-1:0];
    win_we    = req_we[win_idx];
    win_addr  = req_addr[int'(win_idx) * AW +: AW];
    win_wdata = req_wdata[int'(win_idx) * DW +: DW];
  end

  // Next-state and registered-output logic; strobes/valids default low,
  // bus address/data and read data hold their last values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    wr_s_d      = 1'b0;
    rd_s_d      = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        if (win_any) begin
          owner_d = win_idx;
          we_d    = win_we;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          gnt_d   = N_REQ'(1) << win_idx;
          wr_s_d  = win_we;
          rd_s_d  = ~win_we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (cnt_q == '0) begin
          rdata_d     = xa_data_rd;
          rsp_valid_d = N_REQ'(1) << owner_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, pointer and output registers; reset clears everything, which
  // also abandons any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      wr_s_q      <= 1'b0;
      rd_s_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      wr_s_q      <= wr_s_d;
      rd_s_q      <= rd_s_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign xa_wr_s    = wr_s_q;
  assign xa_rd_s    = rd_s_q;
  assign xa_addr    = addr_q;
  assign xa_data_wr = wdata_q;
  assign busy       = busy_q;

`ifndef SYNTHESIS
  // Structural invariants of the sequencer
  a_strobe_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_s_q && rd_s_q));
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q));
  a_gnt_in_issue : assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_q != '0) |-> (state_q == ISSUE));
  a_rsp_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(rsp_valid_q));
  a_rsp_in_resp : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid_q != '0) |-> (state_q == RESP));
  a_busy_state : assert property (@(posedge clk) disable iff (!rst_n)
    busy_q == (state_q != IDLE));
`endif

endmodule

// File: tb/tb_sif_xa_arbiter.sv
// Bench for sif_xa_arbiter: directed scenarios plus random traffic checked
// cycle by cycle against a transaction-level timeline model.
module tb_sif_xa_arbiter;

  localparam int N_REQ  = 4;
  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int RD_LAT = 2;
  localparam int MAXC   = 8192;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req, req_we;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    gnt, rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic                xa_wr_s, xa_rd_s;
  logic [AW-1:0]       xa_addr;
  logic [DW-1:0]       xa_data_wr, xa_data_rd;
  logic                busy;

  always #5 clk = ~clk;

  sif_xa_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .xa_wr_s(xa_wr_s),
    .xa_rd_s(xa_rd_s), .xa_addr(xa_addr), .xa_data_wr(xa_data_wr),
    .xa_data_rd(xa_data_rd), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected timeline, indexed by cycle number
  bit [N_REQ-1:0] e_gnt [MAXC];
  bit             e_wr  [MAXC];
  bit             e_rd  [MAXC];
  bit             e_busy[MAXC];
  bit [N_REQ-1:0] e_rsp [MAXC];
  int             e_src [MAXC];
  bit             e_upd [MAXC];
  bit [AW-1:0]    e_addr[MAXC];
  bit [DW-1:0]    e_wd  [MAXC];
  bit [DW-1:0]    sd    [MAXC];
  bit [AW-1:0]    cur_addr;
  bit [DW-1:0]    cur_wd, cur_rd;
  int             m_ptr, m_free, cyc;

  // Requester agents
  bit [N_REQ-1:0] r_req, r_we, r_hold, req_prev;
  bit [AW-1:0]    r_addr[N_REQ];
  bit [DW-1:0]    r_wd  [N_REQ];
  int             wcnt  [N_REQ];
  bit             rand_en, sd_fix;
  bit [DW-1:0]    sd_fixv;
  int             gq[$];
  int             gcyc[$];
  int             last_wr_cyc, last_rsp_cyc;

  task automatic new_fields(input int i);
    r_we[i]   = 1'($urandom_range(0, 1));
    r_addr[i] = AW'($urandom);
    r_wd[i]   = DW'($urandom);
  endtask

  // Transaction-level rule: an idle bus picks the first requester at or
  // after ptr; a write occupies 2 cycles, a read RD_LAT+3 including IDLE.
  task automatic model(input int c);
    int w;
    if (c >= m_free && r_req != '0) begin
      w = -1;
      for (int k = 0; k < N_REQ; k++) begin
        if (w < 0 && r_req[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
      end
      e_gnt[c+1]  = N_REQ'(1) << w;
      e_upd[c+1]  = 1'b1;
      e_addr[c+1] = r_addr[w];
      e_wd[c+1]   = r_wd[w];
      if (r_we[w]) begin
        e_wr[c+1] = 1'b1;
        m_free    = c + 2;
      end else begin
        e_rd[c+1]            = 1'b1;
        e_rsp[c+RD_LAT+2]    = N_REQ'(1) << w;
        e_src[c+RD_LAT+2]    = c + 1 + RD_LAT;
        m_free               = c + RD_LAT + 3;
      end
      for (int b = c + 1; b < m_free; b++) e_busy[b] = 1'b1;
      m_ptr = (w + 1) % N_REQ;
    end
  endtask

  task automatic clear_model_from(input int c);
    for (int b = c; b < MAXC; b++) begin
      e_gnt[b] = '0; e_wr[b] = 1'b0; e_rd[b] = 1'b0; e_busy[b] = 1'b0;
      e_rsp[b] = '0; e_src[b] = 0; e_upd[b] = 1'b0;
    end
  endtask

  task automatic drive();
    req    = r_req;
    req_we = r_we;
    for (int i = 0; i < N_REQ; i++) begin
      req_addr[i*AW +: AW]  = r_addr[i];
      req_wdata[i*DW +: DW] = r_wd[i];
    end
  endtask

  task automatic step();
    int g;
    @(posedge clk);
    cyc++;
    if (cyc + RD_LAT + 4 >= MAXC) begin
      $display("FAIL cycle_budget got %0d expected below %0d", cyc, MAXC);
      n_errors++;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $fatal(1, "cycle budget exhausted");
    end
    #1;
    if (e_upd[cyc]) begin
      cur_addr = e_addr[cyc];
      cur_wd   = e_wd[cyc];
    end
    if (e_rsp[cyc] != '0) cur_rd = sd[e_src[cyc]];
    chk("gnt", gnt, e_gnt[cyc]);
    chk("xa_wr_s", xa_wr_s, e_wr[cyc]);
    chk("xa_rd_s", xa_rd_s, e_rd[cyc]);
    chk("xa_addr", xa_addr, cur_addr);
    chk("xa_data_wr", xa_data_wr, cur_wd);
    chk("rsp_valid", rsp_valid, e_rsp[cyc]);
    chk("rsp_rdata", rsp_rdata, cur_rd);
    chk("busy", busy, e_busy[cyc]);
    chk("strobe_excl", xa_wr_s & xa_rd_s, 1'b0);
    if (gnt != '0) begin
      g = -1;
      for (int i = N_REQ - 1; i >= 0; i--) if (gnt[i]) g = i;
      gq.push_back(g);
      gcyc.push_back(cyc);
      for (int i = 0; i < N_REQ; i++) begin
        if (i == g) begin
          chk("fair_wait", wcnt[i] <= N_REQ - 1, 1'b1);
          wcnt[i] = 0;
        end else if (req_prev[i]) begin
          wcnt[i]++;
        end
      end
      if (xa_wr_s) last_wr_cyc = cyc;
    end
    if (rsp_valid != '0) last_rsp_cyc = cyc;
    for (int i = 0; i < N_REQ; i++) begin
      if (e_gnt[cyc][i]) begin
        if (r_hold[i] || (rand_en && $urandom_range(0, 1) == 1)) new_fields(i);
        else r_req[i] = 1'b0;
      end else if (!r_req[i] && rand_en && $urandom_range(0, 3) == 0) begin
        r_req[i] = 1'b1;
        new_fields(i);
      end
    end
    drive();
    sd[cyc]    = sd_fix ? sd_fixv : DW'($urandom);
    xa_data_rd = sd[cyc];
    req_prev   = r_req;
    model(cyc);
  endtask

  task automatic drain();
    for (int s = 0; s < 40 && (r_req != '0 || cyc < m_free); s++) step();
  endtask

  initial begin
    int f;
    rst_n = 1'b0;
    r_req = '0; r_we = '0; r_hold = '0; req_prev = '0;
    for (int i = 0; i < N_REQ; i++) begin
      r_addr[i] = '0; r_wd[i] = '0; wcnt[i] = 0;
    end
    rand_en = 1'b0; sd_fix = 1'b0; sd_fixv = '0;
    drive();
    xa_data_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr", xa_wr_s, 0);
    chk("rst_rd", xa_rd_s, 0);
    chk("rst_addr", xa_addr, 0);
    chk("rst_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    cyc = 0; m_ptr = 0; m_free = 1;
    cur_addr = '0; cur_wd = '0; cur_rd = '0;
    repeat (2) step();

    // Single write from requester 0
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_addr[0] = 16'h0010; r_wd[0] = 16'hA5A5;
    step();
    step();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_wr", xa_wr_s, 1'b1);
    chk("t1_addr", xa_addr, 16'h0010);
    chk("t1_wdata", xa_data_wr, 16'hA5A5);
    chk("t1_busy", busy, 1'b1);
    step();
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_wr_end", xa_wr_s, 1'b0);
    chk("t1_no_rsp", rsp_valid, 0);

    // Read from requester 2, slave returns 0xBEEF
    sd_fix = 1'b1; sd_fixv = 16'hBEEF;
    r_req[2] = 1'b1; r_we[2] = 1'b0; r_addr[2] = 16'h0042; r_wd[2] = 16'h0000;
    step();
    step();
    chk("t2_gnt", gnt, 4'b0100);
    chk("t2_rd", xa_rd_s, 1'b1);
    chk("t2_addr", xa_addr, 16'h0042);
    repeat (3) step();
    chk("t2_rsp", rsp_valid, 4'b0100);
    chk("t2_rdata", rsp_rdata, 16'hBEEF);
    step();
    chk("t2_idle", busy, 1'b0);
    sd_fix = 1'b0;

    // Reset during WAIT_RD drops the read
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 16'h0123;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    r_req = '0; r_hold = '0;
    drive();
    #1;
    chk("t5_gnt", gnt, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rd", xa_rd_s, 0);
    chk("t5_addr", xa_addr, 0);
    chk("t5_rsp", rsp_valid, 0);
    clear_model_from(cyc + 1);
    cur_addr = '0; cur_wd = '0; cur_rd = '0;
    m_ptr = 0; m_free = cyc + 1; req_prev = '0;
    for (int i = 0; i < N_REQ; i++) wcnt[i] = 0;
    #3;
    rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      chk("t5_no_rsp", rsp_valid, 0);
    end

    // All four write at once: grants 0,1,2,3 two cycles apart
    gq.delete(); gcyc.delete();
    for (int i = 0; i < N_REQ; i++) begin
      r_req[i] = 1'b1; r_we[i] = 1'b1; r_addr[i] = AW'(16'h0100 + i); r_wd[i] = DW'(i);
    end
    for (int s = 0; s < 20 && gq.size() < 4; s++) step();
    chk("t3_count", gq.size(), 4);
    for (int k = 0; k < 4 && k < gq.size(); k++) chk("t3_order", gq[k], k);
    for (int k = 1; k < 4 && k < gcyc.size(); k++) chk("t3_gap", gcyc[k] - gcyc[k-1], 2);
    drain();
    gq.delete();
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_req[3] = 1'b1; r_we[3] = 1'b1;
    for (int s = 0; s < 10 && gq.size() < 1; s++) step();
    chk("t3_ptr0", (gq.size() > 0) ? gq[0] : -1, 0);
    drain();

    // Requester 1 held continuously, requester 3 joins later
    gq.delete();
    r_hold[1] = 1'b1; r_req[1] = 1'b1; new_fields(1);
    repeat (6) step();
    r_hold[3] = 1'b1; r_req[3] = 1'b1; new_fields(3);
    repeat (24) step();
    f = -1;
    for (int k = gq.size() - 1; k >= 0; k--) if (gq[k] == 3) f = k;
    chk("t4_seen3", f >= 0, 1'b1);
    if (f >= 0) begin
      for (int k = f; k < gq.size(); k++) chk("t4_alt", gq[k], ((k - f) % 2 == 0) ? 3 : 1);
    end
    r_hold = '0;
    drain();

    // Read from 0, write from 1 arrives during the read
    last_wr_cyc = -1; last_rsp_cyc = -1;
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 16'h0200;
    step();
    r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 16'h0201; r_wd[1] = 16'h1234;
    for (int s = 0; s < 15 && last_wr_cyc < 0; s++) step();
    chk("t6_rsp_seen", last_rsp_cyc >= 0, 1'b1);
    chk("t6_wr_after_resp", last_wr_cyc, last_rsp_cyc + 2);
    drain();

    // Random traffic
    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    drain();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sif_xa_arbiter.md
Name: sif_xa_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single SIF XA access port (read/write strobes, 16-bit address and data) between N_REQ independent requesters. It owns the XA strobe, address and write-data outputs. It issues exactly one transaction at a time and holds the bus for the read latency of the XA slave. It returns read data to the requester that issued the read. It sits between the internal bus masters and the SIF XA pins, on the same clock as the SIF interface.

Parameters:
N_REQ, 4, number of requesters (2..8)
AW, 16, address width
DW, 16, data width
RD_LAT, 2, cycles from the xa_rd_s strobe cycle to valid xa_data_rd (1..15)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request; held with fields stable until gnt
req_we  in  N_REQ  1 = write, 0 = read
req_addr  in  N_REQ*AW  packed addresses; requester i at [i*AW +: AW]
req_wdata  in  N_REQ*DW  packed write data; same packing
gnt  out  N_REQ  one-cycle grant pulse, one-hot or zero
rsp_valid  out  N_REQ  one-cycle read-response pulse to the owning requester
rsp_rdata  out  DW  read data, valid while any rsp_valid bit is high
xa_wr_s  out  1  XA write strobe
xa_rd_s  out  1  XA read strobe
xa_addr  out  AW  XA address
xa_data_wr  out  DW  XA write data
xa_data_rd  in  DW  XA read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- Reset: all outputs 0, state IDLE, rr pointer 0, owner 0, latency counter 0. A reset mid-read drops the read; no rsp_valid follows.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP. All outputs are registered.
- IDLE: if req is nonzero, select the first set bit searching from ptr upward, wrapping at N_REQ. Register the winner's addr, wdata and we, and record the winner as owner. Go to ISSUE. If req is zero, stay in IDLE.
- ISSUE (1 cycle):
  - Outputs: gnt[owner]=1; xa_wr_s=we or xa_rd_s=!we; xa_addr/xa_data_wr = the captured values.
  - Set ptr = (owner+1) mod N_REQ.
  - Write: go to IDLE. Read: load counter with RD_LAT-1 and go to WAIT_RD.
- WAIT_RD: strobes 0. Decrement the counter. When the counter is 0, capture xa_data_rd (strobe at cycle t, capture at the end of cycle t+RD_LAT) and go to RESP.
- RESP (1 cycle): rsp_valid[owner]=1, rsp_rdata = captured data. Then go to IDLE.
- Timing:
  - Request seen in IDLE at cycle t gives strobe and gnt at cycle t+1.
  - Write throughput: 1 per 2 cycles.
  - Read occupancy: RD_LAT+2 cycles; rsp_valid at strobe+RD_LAT+1.
- Requester rule: drop req the cycle after gnt, or keep it high with new fields to request again. A requester may not change its fields while req is high without gnt.
- Invariants:
  - xa_wr_s and xa_rd_s are never both high.
  - At most one gnt bit per cycle, and only in ISSUE.
  - At most one rsp_valid bit per cycle, and only in RESP.
  - No arbitration occurs outside IDLE; requests arriving during ISSUE, WAIT_RD or RESP wait.
- xa_addr, xa_data_wr and rsp_rdata hold their last values when not strobed/valid. Only the strobes and valids return to 0.
- Fairness: a requester waits at most N_REQ-1 transactions after its req rises.

Test Plan:
- Reset, then req[0] write addr 0x0010 data 0xA5A5 -> next cycle gnt=0001, xa_wr_s=1, xa_addr=0x0010, xa_data_wr=0xA5A5 for 1 cycle; busy high 1 cycle; no rsp_valid.
- RD_LAT=2: req[2] read addr 0x0042, slave drives 0xBEEF at strobe+2 -> xa_rd_s 1 cycle, gnt=0100 in the same cycle, rsp_valid=0100 with rsp_rdata=0xBEEF at strobe+3, back to IDLE next cycle.
- All four req high simultaneously as writes, held until granted -> grants in order 0,1,2,3, strobes 2 cycles apart; ptr then 0.
- req[1] held high continuously, req[3] rises later -> grants alternate 1,3,1,3; req[3] is never starved.
- Assert rst_n low during WAIT_RD -> outputs 0 immediately; after release, no rsp_valid appears and the next request is granted normally with ptr=0.
- Mixed traffic: read from 0 (RD_LAT=2) while 1 requests a write -> write strobe only after RESP; xa_wr_s never overlaps the read window; strobes never both high.
